// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes stage: SBOX_PER_CYCLE byte lookups per cycle, valid/ready on both sides.
// Optional inverse S-box selected per block when SUB_BYTES_INV_EN is defined.
module sub_bytes_iter #(
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int NUM_STEPS = 16 / SBOX_PER_CYCLE;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int GRP_W     = 8 * SBOX_PER_CYCLE;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  if (!(SBOX_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_param
    $error("sub_bytes_iter: SBOX_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box, element [x] = S(x).
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [127:0]        work, work_next, work_sub;
  logic [STEP_W-1:0]   step, step_next;
  logic                inv_q;
  logic [GRP_W-1:0]    group_in, group_out;

`ifdef SUB_BYTES_INV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      inv_q <= inv;
    end
  end
`else
  logic unused_inv;
  assign inv_q      = 1'b0;
  assign unused_inv = inv | inv_q;
`endif

  // Pick the byte group addressed by step; group 0 holds bytes 0..P-1.
  if (NUM_STEPS == 1) begin : g_single
    assign group_in = work;
    assign work_sub = group_out;
  end else begin : g_multi
    logic [NUM_STEPS-1:0][GRP_W-1:0] grp, grp_sub;
    always_comb begin
      grp           = work;
      grp_sub       = grp;
      grp_sub[step] = group_out;
    end
    assign group_in = grp[step];
    assign work_sub = grp_sub;
  end

  for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lane
    logic [7:0] b;
    assign b = group_in[8*j +: 8];
`ifdef SUB_BYTES_INV_EN
    assign group_out[8*j +: 8] = inv_q ? SBOX_INV[b] : SBOX_FWD[b];
`else
    assign group_out[8*j +: 8] = SBOX_FWD[b];
`endif
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    step_next  = step;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
          work_next  = in;
          step_next  = '0;
        end
      end
      RUN: begin
        work_next = work_sub;
        step_next = step + 1'b1;
        if (step == LAST_STEP) begin
          state_next = DONE;
          step_next  = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      step  <= '0;
    end else begin
      state <= state_next;
      work  <= work_next;
      step  <= step_next;
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = work;

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes stage that sits directly upstream of the ShiftRows stage in the AES round datapath. It accepts a 128-bit state through a valid/ready handshake and substitutes bytes through a configurable number of S-box lookups per cycle. It then presents the substituted state, in the same byte order, to the ShiftRows input. It trades latency for S-box area.

## Interface
- SBOX_PER_CYCLE, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16.
- NUM_STEPS, derived as 16/SBOX_PER_CYCLE: substitution cycles per block. This is a localparam, not overridable.

- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream state available.
- in_ready  output  1  block can accept a state.
- in  input  128  state to substitute. Byte k = in[8k+7:8k]; byte 15 is in[127:120]; column-major, byte 15 = row 0 col 0.
- inv  input  1  1 = inverse S-box. Sampled with the accepted state.
- out_valid  output  1  substituted state available.
- out_ready  input  1  downstream (ShiftRows consumer) accepts.
- out  output  128  substituted state, same byte order as in.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM with three states: IDLE, RUN, DONE. Registers: work[127:0], step counter, inv_q.
- IDLE:
  - in_ready=1.
  - When in_valid is high: work<=in, inv_q<=inv, step<=0, go to RUN.
- RUN:
  - Each cycle, bytes step*P through step*P+P-1 of work (P=SBOX_PER_CYCLE, byte 0 first) are replaced by S(byte), or Sinv(byte) when inv_q=1.
  - step increments each cycle. When step==NUM_STEPS-1, go to DONE after this update.
  - Bytes outside the current group hold their value.
- DONE:
  - out_valid=1 and out=work. Both stay stable until out_ready is high.
  - On out_valid&&out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. There is no overlap: a new state is accepted only from IDLE.
- out is driven from work at all times. It is meaningful only while out_valid is high.
- The S-box is an arithmetic-free byte lookup (FIPS-197 table), implemented combinationally as P parallel instances.

## Timing
- Reset (rst high at an edge):
  - state=IDLE, step=0, work=0, inv_q=0.
  - Outputs after that edge: out=0, out_valid=0, busy=0, in_ready=1.
  - in_ready is forced to 0 combinationally while rst is high.
- Latency: an accept edge at cycle 0 gives out_valid=1 from cycle NUM_STEPS (for P=4, cycle 4; for P=16, cycle 1).
- Minimum spacing between accepts is NUM_STEPS+2 cycles: accept, NUM_STEPS RUN edges, the DONE handshake edge, then an IDLE accept.
- DONE with out_ready low: hold indefinitely. out and out_valid must not change. in_valid is ignored.
- in_valid is high in RUN or DONE: ignored, no capture. Upstream must hold until in_ready.
- rst asserted mid-RUN or in DONE: the partial result is discarded and the block returns to IDLE on that edge. No out_valid pulse.
- inv changing after acceptance has no effect on the in-flight block.

## Configuration
- SUB_BYTES_INV_EN defined: the inverse S-box table is compiled in, and inv selects forward or inverse per block.
- SUB_BYTES_INV_EN undefined:
  - The inverse table is absent and inv is ignored. inv_q is tied to 0, so the forward S-box is always used.
  - The port list is identical in both builds.

## Test plan
- Reset: hold rst 2 cycles, then release -> out=0, out_valid=0, busy=0, in_ready=1.
- Forward, P=4: in=128'h000102030405060708090a0b0c0d0e0f, inv=0, out_ready=1 -> out_valid in cycle 4 after accept, out=128'h637c777bf26b6fc53001672bfed7ab76. Then IDLE and in_ready=1 on the next cycle.
- Inverse (SUB_BYTES_INV_EN): in=128'h637c777bf26b6fc53001672bfed7ab76, inv=1 -> out=128'h000102030405060708090a0b0c0d0e0f. Without the macro, the same stimulus must give the forward S-box of that input, byte 15 = 8'hfb.
- Backpressure: in=128'h0 with out_ready=0 for 10 cycles -> out=128'h636363...63 held stable and in_ready=0 throughout. Raise out_ready -> one transfer, then IDLE.
- Reset mid-operation: accept in=128'h53535353..., assert rst at RUN step 1 -> no out_valid, in_ready=1 after release. The next block in=128'h53... completes with out=128'hed...ed.
- Parameter sweep: P=1 (latency 16), P=16 (latency 1) with the forward vector above -> identical out. Ignored in_valid during RUN causes no capture.
